// File: rtl/piso_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : piso_pkg                                               |
// | Description : Shared types and sizing helpers for the PISO transmitter|
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package piso_pkg;

  // Transmitter control states: idle line, or shifting a frame out.
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // Number of serial slots per frame: the data bits plus an optional parity bit.
  function automatic int frame_len(input int width, input int parity);
    return width + ((parity != 0) ? 1 : 0);
  endfunction

  // Counter width able to index every slot 0..frame_len-1.
  function automatic int cnt_width(input int width, input int parity);
    return $clog2(frame_len(width, parity));
  endfunction

endpackage
`default_nettype wire

// File: rtl/piso_tx_hold.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : piso_tx_hold                                           |
// | Description : One-entry word buffer with full flag and parity that is |
// |               precomputed when the word is written                   |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module piso_tx_hold
  import piso_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic             full,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_parity
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             par_q, par_d;
  logic             full_q, full_d;

  // Next-state: a write captures the word and its parity; a read empties the entry.
  // Writes only happen while empty and reads only while full, so they never collide.
  always_comb begin
    data_d = data_q;
    par_d  = par_q;
    full_d = full_q;
    if (wr_en) begin
      data_d = wr_data;
      par_d  = ^wr_data;
      full_d = 1'b1;
    end else if (rd_en) begin
      full_d = 1'b0;
    end
  end

  // Buffer registers; reset discards any held word.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= '0;
      par_q  <= 1'b0;
      full_q <= 1'b0;
    end else begin
      data_q <= data_d;
      par_q  <= par_d;
      full_q <= full_d;
    end
  end

  assign full      = full_q;
  assign rd_data   = data_q;
  assign rd_parity = par_q;

endmodule
`default_nettype wire

// File: rtl/piso_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : piso_tx                                                |
// | Description : Parallel-in serial-out transmitter with valid/ready    |
// |               input, optional even parity and a one-word hold buffer |
// |               for gap-free back-to-back frames                       |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module piso_tx
  import piso_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int MSB_FIRST = 1,
  parameter int PARITY    = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] pi,
  input  logic             pi_valid,
  output logic             pi_ready,
  output logic             so,
  output logic             so_valid,
  output logic             last
);

  localparam int FL = frame_len(WIDTH, PARITY);
  localparam int CW = cnt_width(WIDTH, PARITY);
  localparam logic [CW-1:0] C_LAST_CNT = CW'(FL - 1);

  state_e          state_q, state_d;
  logic [FL-1:0]   sr_q, sr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            so_q, so_d;
  logic            so_valid_q, so_valid_d;
  logic            last_q, last_d;

  logic             w_hold_full;
  logic [WIDTH-1:0] w_hold_data;
  logic             w_hold_par;
  logic             w_accept;
  logic             w_at_last;
  logic             w_hold_wr;
  logic             w_hold_rd;
  logic [WIDTH-1:0] w_load_data;
  logic             w_load_par;
  logic [WIDTH-1:0] w_ord;
  logic [FL-1:0]    w_frame;

  // Ready depends only on the registered full flag, never on pi_valid.
  assign pi_ready  = ~w_hold_full;
  assign w_accept  = pi_valid & ~w_hold_full;
  assign w_at_last = (state_q == SHIFT) && (cnt_q == C_LAST_CNT);

  // Mid-frame accepts park in the buffer; on the final slot the buffer is drained
  // into the shifter, otherwise a word arriving on that edge loads straight in.
  assign w_hold_wr = w_accept && (state_q == SHIFT) && !w_at_last;
  assign w_hold_rd = w_at_last && w_hold_full;

  piso_tx_hold #(
    .WIDTH (WIDTH)
  ) u_hold (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (w_hold_wr),
    .wr_data   (pi),
    .rd_en     (w_hold_rd),
    .full      (w_hold_full),
    .rd_data   (w_hold_data),
    .rd_parity (w_hold_par)
  );

  // The buffer is empty whenever a direct load from pi is possible.
  assign w_load_data = w_hold_full ? w_hold_data : pi;
  assign w_load_par  = w_hold_full ? w_hold_par  : ^pi;

  // Arrange data so the first bit to transmit sits at the top of the frame.
  if (MSB_FIRST != 0) begin : g_msb_first
    assign w_ord = w_load_data;
  end else begin : g_lsb_first
    for (genvar i = 0; i < WIDTH; i++) begin : g_rev
      assign w_ord[i] = w_load_data[WIDTH-1-i];
    end
  end

  if (PARITY != 0) begin : g_parity
    assign w_frame = {w_ord, w_load_par};
  end else begin : g_no_parity
    logic w_unused_par;
    assign w_frame      = w_ord;
    assign w_unused_par = w_load_par;
  end

  // Next-state logic: load, shift one bit per cycle, and decide the end-of-frame action.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    so_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (w_accept) begin
          so_d    = w_frame[FL-1];
          sr_d    = {w_frame[FL-2:0], 1'b0};
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (w_at_last) begin
          if (w_hold_full || w_accept) begin
            so_d  = w_frame[FL-1];
            sr_d  = {w_frame[FL-2:0], 1'b0};
            cnt_d = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          so_d  = sr_q[FL-1];
          sr_d  = {sr_q[FL-2:0], 1'b0};
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    so_valid_d = (state_d == SHIFT);
    last_d     = (state_d == SHIFT) && (cnt_d == C_LAST_CNT);
  end

  // State, shifter, counter and registered serial outputs; reset drops any frame in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      sr_q       <= '0;
      cnt_q      <= '0;
      so_q       <= 1'b0;
      so_valid_q <= 1'b0;
      last_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      cnt_q      <= cnt_d;
      so_q       <= so_d;
      so_valid_q <= so_valid_d;
      last_q     <= last_d;
    end
  end

  assign so       = so_q;
  assign so_valid = so_valid_q;
  assign last     = last_q;

endmodule
`default_nettype wire
